line_xfer_ctrl: RTL and testbench

AXI4-Lite master controller that moves one fixed-length line of BEATS words between a local line buffer and memory as a sequence of single-beat AXI4-Lite transactions. Sits between the cache/line buffer and the AXI4-Lite interconnect. Counts completed beats internally and signals line completion. One transaction outstanding at a time; read (line fill) or write (writeback) selected per request.

---
 rtl/line_xfer_ctrl_pkg.sv | 23 ++
 rtl/line_xfer_ctrl_if.sv | 38 +++
 rtl/line_xfer_ctrl_beat_counter.sv | 27 ++
 rtl/line_xfer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_line_xfer_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_xfer_ctrl_pkg.sv
// Shared types and AXI response encodings for the line transfer controller.
package line_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WREQ,
        ST_WRESP,
        ST_DONE
    } xfer_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/line_xfer_ctrl_if.sv
// AXI4-Lite read/write channel bundle between the line controller (master) and interconnect (slave).
interface line_xfer_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   o_araddr;
    logic                    o_arvalid;
    logic                    i_arready;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic [1:0]              i_rresp;
    logic                    i_rvalid;
    logic                    o_rready;
    logic [ADDR_WIDTH-1:0]   o_awaddr;
    logic                    o_awvalid;
    logic                    i_awready;
    logic [DATA_WIDTH-1:0]   o_wdata;
    logic [DATA_WIDTH/8-1:0] o_wstrb;
    logic                    o_wvalid;
    logic                    i_wready;
    logic [1:0]              i_bresp;
    logic                    i_bvalid;
    logic                    o_bready;

    modport master (
        output o_araddr, o_arvalid, o_rready, o_awaddr, o_awvalid,
               o_wdata, o_wstrb, o_wvalid, o_bready,
        input  i_arready, i_rdata, i_rresp, i_rvalid, i_awready,
               i_wready, i_bresp, i_bvalid
    );

    modport slave (
        input  o_araddr, o_arvalid, o_rready, o_awaddr, o_awvalid,
               o_wdata, o_wstrb, o_wvalid, o_bready,
        output i_arready, i_rdata, i_rresp, i_rvalid, i_awready,
               i_wready, i_bresp, i_bvalid
    );

endinterface

// File: rtl/line_xfer_ctrl_beat_counter.sv
// Beat index within a line: synchronous clear, increment enable, last-beat flag.
module beat_counter #(
    parameter  int BEATS = 16,
    localparam int IDX_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == IDX_W'(BEATS - 1));

endmodule

// File: rtl/line_xfer_ctrl.sv
// AXI4-Lite line fill/writeback master, one single-beat transaction outstanding.
// Define AXI_ERR_ABORT_EN to abort a line on SLVERR/DECERR and raise a sticky o_error.
module line_xfer_ctrl #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int BEATS      = 16,
    localparam int IDX_W      = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_start,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [IDX_W-1:0]      o_buf_idx,
    output logic                  o_buf_we,
    output logic [DATA_WIDTH-1:0] o_buf_wdata,
    input  logic [DATA_WIDTH-1:0] i_buf_rdata,
    line_xfer_ctrl_if.master      axi
);
    import line_xfer_pkg::*;

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int LINE_SHIFT = $clog2(BEATS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_SHIFT;

    xfer_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  aw_ok, w_ok;
    logic                  accept;
    logic                  cnt_clr, cnt_inc, last_beat;
    logic                  r_err, b_err;

    assign accept = (state_q == ST_IDLE) && i_start;

    beat_counter #(.BEATS(BEATS)) u_beat_counter (
        .clk  (clk),
        .arst (arst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .idx  (o_buf_idx),
        .last (last_beat)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (accept) begin
                base_q <= i_base_addr & LINE_MASK;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        aw_ok         = 1'b0;
        w_ok          = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        o_buf_we      = 1'b0;
        o_done        = 1'b0;
        axi.o_arvalid = 1'b0;
        axi.o_rready  = 1'b0;
        axi.o_awvalid = 1'b0;
        axi.o_wvalid  = 1'b0;
        axi.o_bready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cnt_clr = 1'b1;
                    state_d = i_write ? ST_WREQ : ST_RADDR;
                end
            end
            ST_RADDR: begin
                axi.o_arvalid = 1'b1;
                if (axi.i_arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                axi.o_rready = 1'b1;
                if (axi.i_rvalid) begin
                    o_buf_we = 1'b1;
                    if (last_beat || r_err) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = ST_RADDR;
                    end
                end
            end
            ST_WREQ: begin
                // AW and W complete independently; each valid drops once its own handshake is done.
                axi.o_awvalid = !aw_done_q;
                axi.o_wvalid  = !w_done_q;
                aw_ok         = aw_done_q || axi.i_awready;
                w_ok          = w_done_q || axi.i_wready;
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            ST_WRESP: begin
                axi.o_bready = 1'b1;
                if (axi.i_bvalid) begin
                    if (last_beat || b_err) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = ST_WREQ;
                    end
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat_addr    = base_q + (ADDR_WIDTH'(o_buf_idx) << BYTE_SHIFT);
    assign axi.o_araddr = beat_addr;
    assign axi.o_awaddr = beat_addr;
    assign axi.o_wdata  = i_buf_rdata;
    assign axi.o_wstrb  = '1;
    assign o_buf_wdata  = axi.i_rdata;
    assign o_busy       = (state_q != ST_IDLE);

`ifdef AXI_ERR_ABORT_EN
    logic err_q;
    logic err_set;

    assign r_err   = resp_is_err(axi.i_rresp);
    assign b_err   = resp_is_err(axi.i_bresp);
    assign err_set = ((state_q == ST_RDATA) && axi.i_rvalid && r_err) ||
                     ((state_q == ST_WRESP) && axi.i_bvalid && b_err);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign o_error = err_q;
`else
    logic unused_resp;

    assign r_err       = 1'b0;
    assign b_err       = 1'b0;
    assign unused_resp = ^{axi.i_rresp, axi.i_bresp};
    assign o_error     = 1'b0;
`endif

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Scoreboard bench for line_xfer_ctrl: slave model with configurable backpressure and expected-transfer queues.
`timescale 1ns/1ps
module tb_line_xfer_ctrl;
    import line_xfer_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BEATS = 16;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;

    logic        clk = 1'b0;
    logic        arst;
    logic        i_start, i_write;
    logic [31:0] i_base_addr, i_buf_rdata;
    logic        o_busy, o_done, o_error, o_buf_we;
    logic [3:0]  o_buf_idx;
    logic [31:0] o_buf_wdata;

    line_xfer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    line_xfer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .clk         (clk),
        .arst        (arst),
        .i_start     (i_start),
        .i_write     (i_write),
        .i_base_addr (i_base_addr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_buf_idx   (o_buf_idx),
        .o_buf_we    (o_buf_we),
        .o_buf_wdata (o_buf_wdata),
        .i_buf_rdata (i_buf_rdata),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] wmem [BEATS];
    logic [31:0] exp_ar[$], exp_aw[$], exp_w[$];
    logic [35:0] exp_buf[$];
    bit          rand_mode = 0;
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    bit          err_inj = 0;
    logic [31:0] err_addr = '0;
    int          done_cnt = 0, done_cyc = 0, b_cnt = 0;

    assign i_buf_rdata = wmem[o_buf_idx];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
    endfunction

    function automatic bit coin();
        return $urandom_range(0, 2) == 0;
    endfunction

    // Slave: drive channel inputs at negedge, then sample the handshakes that complete at the next posedge.
    initial begin : slave
        bit          r_pend, aw_seen, w_seen, b_pend;
        bit          ar_hold, aw_hold, w_hold;
        logic [31:0] r_addr, ar_hold_v, aw_hold_v, w_hold_v;
        logic [35:0] e;
        int          ar_age, aw_age, w_age;
        r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0;
        r_addr = '0; ar_hold_v = '0; aw_hold_v = '0; w_hold_v = '0;
        ar_age = 0; aw_age = 0; w_age = 0;
        axi.i_arready = 0; axi.i_rvalid = 0; axi.i_rdata = '0; axi.i_rresp = RESP_OKAY;
        axi.i_awready = 0; axi.i_wready = 0; axi.i_bvalid = 0; axi.i_bresp = RESP_OKAY;
        forever begin
            @(negedge clk);
            if (arst) begin
                r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
                ar_hold = 0; aw_hold = 0; w_hold = 0;
                ar_age = 0; aw_age = 0; w_age = 0;
                axi.i_arready = 0; axi.i_rvalid = 0; axi.i_awready = 0;
                axi.i_wready = 0; axi.i_bvalid = 0;
                continue;
            end
            axi.i_arready = axi.o_arvalid && (rand_mode ? coin() : (ar_age >= ar_delay));
            axi.i_rvalid  = r_pend && (axi.i_rvalid || !rand_mode || coin());
            axi.i_rdata   = r_pend ? rd_word(r_addr) : '0;
            axi.i_rresp   = (r_pend && err_inj && r_addr == err_addr) ? RESP_SLVERR : RESP_OKAY;
            axi.i_awready = axi.o_awvalid && (rand_mode ? coin() : (aw_age >= aw_delay));
            axi.i_wready  = axi.o_wvalid && (rand_mode ? coin() : (w_age >= w_delay));
            axi.i_bvalid  = b_pend && (axi.i_bvalid || !rand_mode || coin());
            axi.i_bresp   = RESP_OKAY;
            #1;
            if (ar_hold) check("ar_hold", {axi.o_arvalid, axi.o_araddr}, {1'b1, ar_hold_v});
            if (aw_hold) check("aw_hold", {axi.o_awvalid, axi.o_awaddr}, {1'b1, aw_hold_v});
            if (w_hold)  check("w_hold", {axi.o_wvalid, axi.o_wdata}, {1'b1, w_hold_v});
            if (aw_seen) check("aw_drop", axi.o_awvalid, 1'b0);
            if (w_seen)  check("w_drop", axi.o_wvalid, 1'b0);
            check("buf_we_vs_r", o_buf_we, axi.i_rvalid && axi.o_rready);

            if (axi.i_bvalid && axi.o_bready) begin
                b_cnt++;
                b_pend = 0; aw_seen = 0; w_seen = 0;
            end
            if (axi.o_arvalid && axi.i_arready) begin
                check("ar_expected", exp_ar.size() > 0, 1'b1);
                if (exp_ar.size() > 0) check("ar_addr", axi.o_araddr, exp_ar.pop_front());
                r_pend = 1; r_addr = axi.o_araddr; ar_age = 0; ar_hold = 0;
            end else begin
                ar_hold = axi.o_arvalid; ar_hold_v = axi.o_araddr;
                if (axi.o_arvalid) ar_age++;
            end
            if (axi.i_rvalid && axi.o_rready) r_pend = 0;
            if (o_buf_we) begin
                check("buf_expected", exp_buf.size() > 0, 1'b1);
                if (exp_buf.size() > 0) begin
                    e = exp_buf.pop_front();
                    check("buf_idx", o_buf_idx, e[35:32]);
                    check("buf_wdata", o_buf_wdata, e[31:0]);
                end
            end
            if (axi.o_awvalid && axi.i_awready) begin
                check("aw_expected", exp_aw.size() > 0, 1'b1);
                if (exp_aw.size() > 0) check("aw_addr", axi.o_awaddr, exp_aw.pop_front());
                aw_seen = 1; aw_age = 0; aw_hold = 0;
            end else begin
                aw_hold = axi.o_awvalid; aw_hold_v = axi.o_awaddr;
                if (axi.o_awvalid) aw_age++;
            end
            if (axi.o_wvalid && axi.i_wready) begin
                check("w_expected", exp_w.size() > 0, 1'b1);
                if (exp_w.size() > 0) check("w_data", axi.o_wdata, exp_w.pop_front());
                check("wstrb", axi.o_wstrb, 4'hF);
                w_seen = 1; w_age = 0; w_hold = 0;
            end else begin
                w_hold = axi.o_wvalid; w_hold_v = axi.o_wdata;
                if (axi.o_wvalid) w_age++;
            end
            if (aw_seen && w_seen) b_pend = 1;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_fill(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ar.push_back(b + 32'(4 * i));
            exp_buf.push_back({4'(i), rd_word(b + 32'(4 * i))});
        end
    endtask

    task automatic run_line(input bit wr, input logic [31:0] base, input bit timing,
                            input bit poke, input int err_beat);
        logic [31:0] b;
        int          n, d0, b0, start_c, k;
        bit          exp_err;
        b = base & LINE_MASK;
`ifdef AXI_ERR_ABORT_EN
        n       = (err_beat >= 0) ? err_beat + 1 : BEATS;
        exp_err = (err_beat >= 0);
`else
        n       = BEATS;
        exp_err = 0;
`endif
        err_inj  = (err_beat >= 0);
        err_addr = b + 32'(4 * err_beat);
        for (int i = 0; i < BEATS; i++) wmem[i] = $urandom;
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                exp_aw.push_back(b + 32'(4 * i));
                exp_w.push_back(wmem[i]);
            end
        end else begin
            push_fill(b, n);
        end
        d0 = done_cnt;
        b0 = b_cnt;
        @(negedge clk);
        i_start = 1; i_write = wr; i_base_addr = base; start_c = cyc;
        @(negedge clk);
        i_start = 0; i_write = !wr; i_base_addr = 32'hDEAD_BEEF;
        #2;
        check("busy_c1", o_busy, 1'b1);
        check("err_clr", o_error, 1'b0);
        if (poke) begin
            repeat (3) @(negedge clk);
            i_start = 1; i_base_addr = 32'h0000_8000;
            @(negedge clk);
            i_start = 0;
        end
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("done_seen", done_cnt != d0, 1'b1);
        if (timing) check("done_cycle", done_cyc - start_c, 2 * BEATS + 1);
        repeat (3) @(negedge clk);
        #2;
        check("done_once", done_cnt - d0, 1);
        check("busy_idle", o_busy, 1'b0);
        check("err_flag", o_error, exp_err);
        check("ar_left", exp_ar.size(), 0);
        check("buf_left", exp_buf.size(), 0);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        if (wr) check("b_count", b_cnt - b0, n);
        err_inj = 0;
    endtask

    initial begin : main
        int k;
        arst = 1; i_start = 0; i_write = 0; i_base_addr = '0;
        for (int i = 0; i < BEATS; i++) wmem[i] = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_state", {o_busy, o_done, o_error, o_buf_we, o_buf_idx, axi.o_arvalid,
                            axi.o_rready, axi.o_awvalid, axi.o_wvalid, axi.o_bready}, '0);
        arst = 0;

        run_line(0, 32'h0000_1000, 1, 0, -1);          // zero-wait fill, o_done at cycle 33
        aw_delay = 3; w_delay = 1;
        run_line(1, 32'h0000_2040, 0, 0, -1);          // AW/W accepted in different cycles
        aw_delay = 0; w_delay = 0;
        run_line(1, 32'h0000_2080, 1, 0, -1);          // zero-wait writeback timing
        rand_mode = 1;
        run_line(0, 32'h0000_3000, 0, 0, -1);
        run_line(1, 32'hFFFF_FFC0, 0, 0, -1);
        rand_mode = 0;
        run_line(0, 32'h0000_1004, 1, 1, -1);          // unaligned base, start pulsed while busy
        run_line(0, 32'h0000_4000, 0, 0, 5);           // SLVERR on beat 5

        // Reset in the RDATA cycle of beat 7, then a fresh line from index 0.
        push_fill(32'h0000_6000, BEATS);
        @(negedge clk);
        i_start = 1; i_write = 0; i_base_addr = 32'h0000_6000;
        @(negedge clk);
        i_start = 0;
        k = 0;
        #2;
        while (!(axi.o_rready && o_buf_idx == 4'd7) && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("reach_beat7", axi.o_rready && o_buf_idx == 4'd7, 1'b1);
        arst = 1;
        #1;
        check("rst_mid", {axi.o_arvalid, axi.o_rready, o_busy, o_buf_idx}, '0);
        exp_ar.delete();
        exp_buf.delete();
        repeat (2) @(negedge clk);
        #3;
        arst = 0;
        run_line(0, 32'h0000_6000, 1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
